// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and oversampling constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int OVERSAMPLE  = 16;
    localparam int MID_TICK    = 7;
    localparam int DEF_DBIT    = 8;
    localparam int DEF_SB_TICK = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Reset value is a parameter so an idle-high line does not look like activity out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver driven by a 16x oversampling tick; delivers each frame as a
// registered byte with a one-cycle done strobe and a framing-error flag.
//
// state | meaning
// IDLE  | waiting for the synchronized line to go low
// START | counting to mid start bit; a high line there is a false start
// DATA  | shifting one data bit every 16 ticks, LSB first
// STOP  | timing the stop bit, then presenting the byte
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = DEF_SB_TICK
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);
    localparam logic [3:0]    S_MID       = 4'(MID_TICK);
    localparam logic [3:0]    S_BIT_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]    S_STOP_LAST = 4'(SB_TICK - 1);

    logic w_rx_s;

    uart_state_t     r_state, w_state_nxt;
    logic [3:0]      r_s, w_s_nxt;
    logic [NW-1:0]   r_n, w_n_nxt;
    logic [DBIT-1:0] r_b, w_b_nxt;
    logic            r_stop_s, w_stop_s_nxt;
    logic [DBIT-1:0] r_dout, w_dout_nxt;
    logic            r_done, w_done_nxt;
    logic            r_ferr, w_ferr_nxt;

    sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_s      <= '0;
            r_n      <= '0;
            r_b      <= '0;
            r_stop_s <= 1'b0;
            r_dout   <= '0;
            r_done   <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_s      <= w_s_nxt;
            r_n      <= w_n_nxt;
            r_b      <= w_b_nxt;
            r_stop_s <= w_stop_s_nxt;
            r_dout   <= w_dout_nxt;
            r_done   <= w_done_nxt;
            r_ferr   <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_s_nxt      = r_s;
        w_n_nxt      = r_n;
        w_b_nxt      = r_b;
        w_stop_s_nxt = r_stop_s;
        w_dout_nxt   = r_dout;
        w_done_nxt   = 1'b0;
        w_ferr_nxt   = r_ferr;

        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = START;
                    w_s_nxt     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (r_s == S_MID) begin
                        if (!w_rx_s) begin
                            w_state_nxt = DATA;
                            w_s_nxt     = '0;
                            w_n_nxt     = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_s_nxt = r_s + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (r_s == S_BIT_LAST) begin
                        w_s_nxt = '0;
                        w_b_nxt = {w_rx_s, r_b[DBIT-1:1]};
                        if (r_n == N_LAST) begin
                            w_state_nxt = STOP;
                        end else begin
                            w_n_nxt = r_n + NW'(1);
                        end
                    end else begin
                        w_s_nxt = r_s + 4'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (r_s == S_STOP_LAST) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                        w_dout_nxt  = r_b;
                        // A very short stop period can end on the sample tick itself.
                        w_ferr_nxt  = ~((r_s == S_MID) ? w_rx_s : r_stop_s);
                    end else begin
                        if (r_s == S_MID) begin
                            w_stop_s_nxt = w_rx_s;
                        end
                        w_s_nxt = r_s + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign dout         = r_dout;
    assign rx_done_tick = r_done;
    assign frame_err    = r_ferr;

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the stage directly downstream of the baud tick generator. It consumes the generator's 16x-oversampling `tick` pulse and recovers 8N1 frames from the asynchronous `rx` line. Each completed frame is delivered as a parallel byte with a one-cycle done strobe and a framing-error flag. It feeds the receive FIFO / host interface.

## Interface
- `DBIT`, 8: data bits per frame, LSB first.
- `SB_TICK`, 16: oversampling ticks spent in the stop state (16 = 1 stop bit).
- `clk` input 1: system clock, all logic on rising edge.
- `reset` input 1: reset is synchronous and active-low. The block resets when `reset`==0 at a rising `clk` edge.
- `rx` input 1: asynchronous serial line, idle high.
- `s_tick` input 1: one-cycle enable pulse from the baud generator, 16 per bit period.
- `dout` output DBIT: last received byte, held until the next completed frame.
- `rx_done_tick` output 1: one-cycle pulse when `dout` is updated.
- `frame_err` output 1: stop bit sampled low on the frame just delivered. Updated together with `dout`.

## Operation
- `rx` passes through a 2-flop synchronizer; all FSM decisions use the synchronized `rx_s`.
- Synchronizer flops reset to 1.
- Internal registers:
  - `s`: 4-bit tick counter.
  - `n`: bit counter, $clog2(DBIT) bits.
  - `b`: DBIT-bit shift register.
  - `stop_s`: 1-bit stop-bit sample.
- State **IDLE**: `s_tick` is ignored. If `rx_s`==0, go to START with `s`=0.
- State **START**: on `s_tick`:
  - If `s`==7 (mid start bit) and `rx_s`==0: go to DATA, `s`=0, `n`=0.
  - If `s`==7 and `rx_s`==1: false start, go to IDLE with no output activity.
  - Otherwise `s`++.
- State **DATA**: on `s_tick`:
  - If `s`==15: `s`=0 and `b`={`rx_s`, `b`[DBIT-1:1]}. If `n`==DBIT-1, go to STOP; otherwise `n`++.
  - Otherwise `s`++.
- State **STOP**: on `s_tick`:
  - At `s`==7, capture `stop_s`=`rx_s`.
  - At `s`==SB_TICK-1, go to IDLE and register `dout`=`b`, `frame_err`=~`stop_s`, `rx_done_tick`=1.
  - Otherwise `s`++.
- Cycles without `s_tick` hold all state in START, DATA and STOP.
- `rx_done_tick` is 0 on every cycle except the one following frame completion.
- `dout` and `frame_err` change only at frame completion.
- A low line in IDLE after STOP immediately starts the next frame, so back-to-back frames are supported.
- A framing error does not suppress delivery; the byte is still presented, with `frame_err`=1.

## Timing
- Reset values: `dout`=0, `rx_done_tick`=0, `frame_err`=0, state=IDLE, `s`=`n`=0, `b`=0, synchronizer=1.
- Reset mid-frame: the next edge returns the block to IDLE with the outputs above. No done pulse is generated for the partial frame.
- Synchronizer latency: 2 clocks from `rx` to `rx_s`.
- With `s_tick` continuously high, DBIT=8, SB_TICK=16:
  - Edge E0 (IDLE sees `rx_s`=0): enter START.
  - E8: enter DATA.
  - E136: enter STOP.
  - E152: outputs registered, so `rx_done_tick` is high in the cycle after E152.
- In general the frame takes 8 + 16·DBIT + SB_TICK `s_tick` pulses after START entry.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum {IDLE, START, DATA, STOP}.
  - `OVERSAMPLE`=16.
  - `MID_TICK`=7.
  - Default `DBIT`/`SB_TICK` constants, for reuse by the future `uart_tx`.
- One natural sub-module: `sync_2ff`, a parameterized-reset-value 2-flop synchronizer.
- The FSM and datapath stay in `uart_rx`.

## Test plan
- Frame 0x55, `s_tick` every 4 clocks, stop=1: one `rx_done_tick` pulse, `dout`=0x55, `frame_err`=0.
- `rx` low for 4 ticks then high (glitch): FSM returns to IDLE at tick 8, no `rx_done_tick`, `dout` unchanged.
- Frame 0xA3 with stop bit driven 0: `rx_done_tick` pulses, `dout`=0xA3, `frame_err`=1. The following 0x3C frame with a good stop bit gives `frame_err`=0.
- `reset`=0 for 1 clock during the 4th data bit of 0xFF: all outputs 0 next cycle, no done pulse. The subsequent frame 0x0F gives `dout`=0x0F.
- Back-to-back 0x00 then 0xFF with no idle gap: exactly two done pulses, `dout`=0x00 then 0xFF.
- `s_tick` held high, frame 0x81: `rx_done_tick` high in the cycle after the 152nd edge following IDLE detecting `rx_s`=0, `dout`=0x81.
